// File: rtl/fpadd_sched_if.sv
// fpadd_sched_if: request/response/adder signal bundle for the FP add scheduler.
interface fpadd_sched_if;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_sub, req1_sub;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_result;
    logic [31:0] fpa_a, fpa_b, fpa_result;
    logic        busy;
    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_sub, req1_sub,
        input  resp_ready, fpa_result,
        output req0_ready, req1_ready, resp_valid, resp_id, resp_result, fpa_a, fpa_b, busy
    );
    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_sub, req1_sub,
        output resp_ready, fpa_result,
        input  req0_ready, req1_ready, resp_valid, resp_id, resp_result, fpa_a, fpa_b, busy
    );
endinterface

// File: rtl/fpadd_sched.sv
// fpadd_sched: round-robin arbiter sharing one combinational FP adder between two requesters.
module fpadd_sched #(
    parameter int EXEC_CYCLES = 1
) (
    input logic          clk,
    input logic          reset,
    fpadd_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam logic [1:0] CNT_INIT = 2'(EXEC_CYCLES - 1);

    state_t      r_state, w_next;
    logic        r_last_grant, r_id;
    logic [1:0]  r_cnt;
    logic [31:0] r_a, r_b, r_result;
    logic        w_grant, w_accept, w_sub;

    always_comb begin
        w_grant  = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant :
                   bus.req0_valid ? 1'b0 : bus.req1_valid ? 1'b1 : ~r_last_grant;
        w_accept = (r_state == IDLE) && (w_grant ? bus.req1_valid : bus.req0_valid);
        w_sub    = w_grant ? bus.req1_sub : bus.req0_sub;
        w_next   = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? EXEC : IDLE;
            EXEC:    w_next = (r_cnt == 2'd0) ? RESP : EXEC;
            RESP:    w_next = bus.resp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Operands are captured once at accept so requesters may change freely afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_cnt        <= 2'd0;
            r_a          <= '0;
            r_b          <= '0;
            r_result     <= '0;
        end else if (w_accept) begin
            r_a          <= w_grant ? bus.req1_a : bus.req0_a;
            r_b          <= (w_grant ? bus.req1_b : bus.req0_b) ^ {w_sub, 31'b0};
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            r_cnt        <= CNT_INIT;
        end else if (r_state == EXEC) begin
            if (r_cnt == 2'd0) r_result <= bus.fpa_result;
            else               r_cnt    <= r_cnt - 2'd1;
        end
    end

    assign bus.req0_ready  = (r_state == IDLE) && !w_grant;
    assign bus.req1_ready  = (r_state == IDLE) && w_grant;
    assign bus.resp_valid  = (r_state == RESP);
    assign bus.resp_id     = r_id;
    assign bus.resp_result = r_result;
    assign bus.fpa_a       = r_a;
    assign bus.fpa_b       = r_b;
    assign bus.busy        = (r_state != IDLE);
endmodule

// File: tb/tb_fpadd_sched.sv
// tb_fpadd_sched: directed checks of the FP add scheduler with a table-driven stand-in adder.
module tb_fpadd_sched;
    logic clk = 1'b0;
    logic r1 = 1'b1;
    logic r3 = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    fpadd_sched_if b1();
    fpadd_sched_if b3();

    fpadd_sched #(.EXEC_CYCLES(1)) u_d1 (.clk(clk), .reset(r1), .bus(b1));
    fpadd_sched #(.EXEC_CYCLES(3)) u_d3 (.clk(clk), .reset(r3), .bus(b3));

    // Stand-in adder knows only the sums used here; anything else returns a marker value.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: fadd = 32'h40400000;
            64'h40400000_BF800000: fadd = 32'h40000000;
            default:               fadd = 32'hDEADBEEF;
        endcase
    endfunction

    assign b1.fpa_result = fadd(b1.fpa_a, b1.fpa_b);
    assign b3.fpa_result = fadd(b3.fpa_a, b3.fpa_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [31:0] exp_b, input logic [31:0] exp_res);
        int k;
        if (!id) begin
            b1.req0_valid = 1'b1; b1.req0_a = a; b1.req0_b = b; b1.req0_sub = sub;
        end else begin
            b1.req1_valid = 1'b1; b1.req1_a = a; b1.req1_b = b; b1.req1_sub = sub;
        end
        b1.resp_ready = 1'b1;
        #1;
        check("grant", {31'b0, id ? b1.req1_ready : b1.req0_ready}, 32'd1);
        step();
        b1.req0_valid = 1'b0; b1.req1_valid = 1'b0;
        b1.req0_a = '1; b1.req0_b = '1; b1.req1_a = '1; b1.req1_b = '1;
        #1;
        check("exec_busy", {31'b0, b1.busy}, 32'd1);
        check("exec_fpa_b", b1.fpa_b, exp_b);
        k = 1;
        while (!b1.resp_valid && k < 10) begin
            step();
            k++;
        end
        check("latency", k, 32'd2);
        check("result", b1.resp_result, exp_res);
        check("resp_id", {31'b0, b1.resp_id}, {31'b0, id});
        step();
        check("idle_busy", {31'b0, b1.busy}, 32'd0);
    endtask

    initial begin
        int k;
        int nacc;
        int nresp;
        logic both_ready;
        logic saw_valid;
        logic [31:0] held_res;
        logic held_id;
        logic acc_ids[$];
        logic resp_ids[$];

        {b1.req0_valid, b1.req1_valid, b1.req0_sub, b1.req1_sub, b1.resp_ready} = '0;
        {b1.req0_a, b1.req0_b, b1.req1_a, b1.req1_b} = '0;
        {b3.req0_valid, b3.req1_valid, b3.req0_sub, b3.req1_sub, b3.resp_ready} = '0;
        {b3.req0_a, b3.req0_b, b3.req1_a, b3.req1_b} = '0;
        step(); step();
        r1 = 1'b0; r3 = 1'b0;
        #1;
        check("rst_busy", {31'b0, b1.busy}, 32'd0);
        check("rst_resp_valid", {31'b0, b1.resp_valid}, 32'd0);
        check("rst_result", b1.resp_result, 32'd0);
        check("rst_id", {31'b0, b1.resp_id}, 32'd0);
        check("rst_fpa_a", b1.fpa_a, 32'd0);
        check("rst_fpa_b", b1.fpa_b, 32'd0);
        check("rst_ready0", {31'b0, b1.req0_ready}, 32'd1);
        check("rst_ready1", {31'b0, b1.req1_ready}, 32'd0);

        run_op(1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 32'h40400000);
        #1;
        check("idle_ready1_after0", {31'b0, b1.req1_ready}, 32'd1);
        run_op(1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 32'h40400000);
        run_op(1'b1, 32'h40400000, 32'h3F800000, 1'b1, 32'hBF800000, 32'h40000000);

        // Response held off while both requesters knock.
        b1.req0_valid = 1'b1; b1.req0_a = 32'h3F800000; b1.req0_b = 32'h40000000; b1.req0_sub = 1'b0;
        b1.resp_ready = 1'b0;
        step();
        b1.req1_valid = 1'b1; b1.req1_a = 32'h40400000; b1.req1_b = 32'h3F800000; b1.req1_sub = 1'b1;
        step();
        held_res = b1.resp_result; held_id = b1.resp_id;
        check("hold_enter", {31'b0, b1.resp_valid}, 32'd1);
        check("hold_res0", held_res, 32'h40400000);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'b0, b1.resp_valid}, 32'd1);
            check("hold_result", b1.resp_result, held_res);
            check("hold_id", {31'b0, b1.resp_id}, {31'b0, held_id});
            check("hold_ready", {30'b0, b1.req0_ready, b1.req1_ready}, 32'd0);
            check("hold_busy", {31'b0, b1.busy}, 32'd1);
            step();
        end
        b1.req0_valid = 1'b0; b1.req1_valid = 1'b0; b1.resp_ready = 1'b1;
        #1;
        check("hs_ready", {30'b0, b1.req0_ready, b1.req1_ready}, 32'd0);
        step();
        check("hs_idle", {31'b0, b1.busy}, 32'd0);

        // Alternation from reset with both requesters continuously valid.
        r1 = 1'b1;
        step();
        r1 = 1'b0;
        b1.req0_valid = 1'b1; b1.req0_a = 32'h3F800000; b1.req0_b = 32'h40000000; b1.req0_sub = 1'b0;
        b1.req1_valid = 1'b1; b1.req1_a = 32'h40400000; b1.req1_b = 32'h3F800000; b1.req1_sub = 1'b1;
        b1.resp_ready = 1'b1;
        both_ready = 1'b0; nacc = 0; nresp = 0;
        for (int i = 0; i < 14; i++) begin
            #1;
            both_ready |= b1.req0_ready & b1.req1_ready;
            if (b1.req0_ready && b1.req0_valid) begin acc_ids.push_back(1'b0); nacc++; end
            else if (b1.req1_ready && b1.req1_valid) begin acc_ids.push_back(1'b1); nacc++; end
            if (b1.resp_valid && b1.resp_ready) begin
                resp_ids.push_back(b1.resp_id); nresp++;
                check("alt_result", b1.resp_result, b1.resp_id ? 32'h40000000 : 32'h40400000);
            end
            step();
        end
        b1.req0_valid = 1'b0; b1.req1_valid = 1'b0;
        check("alt_both_ready", {31'b0, both_ready}, 32'd0);
        check("alt_nacc", nacc, 32'd5);
        check("alt_nresp", nresp, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("alt_acc_id", {31'b0, (i < acc_ids.size()) ? acc_ids[i] : 1'bx}, {31'b0, 1'(i % 2)});
            check("alt_resp_id", {31'b0, (i < resp_ids.size()) ? resp_ids[i] : 1'bx}, {31'b0, 1'(i % 2)});
        end

        // EXEC_CYCLES=3: reset in the second EXEC cycle aborts the operation.
        b3.req0_valid = 1'b1; b3.req0_a = 32'h3F800000; b3.req0_b = 32'h40000000; b3.req0_sub = 1'b0;
        b3.resp_ready = 1'b1;
        #1;
        check("e3_grant", {31'b0, b3.req0_ready}, 32'd1);
        step();
        b3.req0_valid = 1'b0;
        check("e3_exec1", {31'b0, b3.busy}, 32'd1);
        step();
        check("e3_exec2", {31'b0, b3.busy}, 32'd1);
        r3 = 1'b1;
        step();
        r3 = 1'b0;
        check("e3_rst_busy", {31'b0, b3.busy}, 32'd0);
        check("e3_rst_valid", {31'b0, b3.resp_valid}, 32'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            saw_valid |= b3.resp_valid;
        end
        check("e3_no_resp", {31'b0, saw_valid}, 32'd0);

        b3.req1_valid = 1'b1; b3.req1_a = 32'h40400000; b3.req1_b = 32'h3F800000; b3.req1_sub = 1'b1;
        #1;
        check("e3_grant1", {31'b0, b3.req1_ready}, 32'd1);
        step();
        b3.req1_valid = 1'b0; b3.req1_b = 32'h0;
        #1;
        check("e3_fpa_b", b3.fpa_b, 32'hBF800000);
        k = 1;
        while (!b3.resp_valid && k < 12) begin
            step();
            k++;
        end
        check("e3_latency", k, 32'd4);
        check("e3_result", b3.resp_result, 32'h40000000);
        check("e3_id", {31'b0, b3.resp_id}, 32'd1);
        step();
        check("e3_idle", {31'b0, b3.busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fpadd_sched.md
FPADD_SCHED -- requirements
Module: fpadd_sched

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, cycles the operands are held on the adder before the sum is sampled (legal 1..4).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  requester n has an operation pending.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1  scheduler accepts requester n this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  32  IEEE-754 single operands.
REQ-007 SHALL have ports req0_sub/req1_sub  input  1  1 = compute a - b, 0 = a + b.
REQ-008 SHALL have port resp_valid  output  1  result available.
REQ-009 SHALL have port resp_ready  input  1  consumer takes result.
REQ-010 SHALL have port resp_id  output  1  index of requester that owns the result.
REQ-011 SHALL have port resp_result  output  32  registered sum.
REQ-012 SHALL have ports fpa_a, fpa_b  output  32  operands to the shared combinational FP adder.
REQ-013 SHALL have port fpa_result  input  32  sum returned by the shared adder.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement three states: IDLE, EXEC, RESP.
REQ-016 IDLE: exactly one of req0_ready/req1_ready SHALL be high, selected combinationally; both low in EXEC and RESP.
REQ-017 Grant: only req0 valid -> req0; only req1 valid -> req1; both valid -> requester not equal to last_grant; none valid -> ready follows the not-last_grant requester.
REQ-018 Accept = granted valid && ready in IDLE; on accept SHALL register a, b with b[31] inverted when sub=1, register id, set last_grant = id, load counter with EXEC_CYCLES-1, go to EXEC.
REQ-019 fpa_a/fpa_b SHALL be driven from operand registers in all states (no combinational path from req inputs).
REQ-020 EXEC: counter decrements each cycle; when counter == 0 SHALL register fpa_result into resp_result and go to RESP.
REQ-021 RESP: resp_valid = 1; resp_result and resp_id SHALL be stable until resp_valid && resp_ready, then go to IDLE.
REQ-022 Latency: accept in cycle T -> resp_valid first high in cycle T+1+EXEC_CYCLES.
REQ-023 No acceptance in the cycle the response handshake completes; next accept no earlier than the following IDLE cycle (max one op per EXEC_CYCLES+2 cycles).
REQ-024 Requester inputs changing during EXEC/RESP SHALL NOT affect the operation in flight.
REQ-025 Arithmetic (NaN, zero, sign) SHALL be whatever fpa_result returns; scheduler only flips b sign for sub.
REQ-026 Starvation: with both requesters continuously valid, grants SHALL strictly alternate.

Reset
REQ-027 On reset: state IDLE, last_grant = 1 (req0 wins first tie), counter 0, operand registers 0, resp_result 0, resp_id 0, resp_valid 0, busy 0.
REQ-028 Reset during EXEC or RESP SHALL discard the operation; no resp_valid produced for it.

Verification
REQ-029 EXEC_CYCLES=1, req0 a=0x3F800000, b=0x40000000, sub=0 accepted cycle T -> resp_valid at T+2, resp_result 0x40400000, resp_id 0.
REQ-030 req1 a=0x40400000, b=0x3F800000, sub=1 -> fpa_b 0xBF800000, resp_result 0x40000000, resp_id 1.
REQ-031 Both valid from reset, resp_ready=1 -> accepts in order req0, req1, req0, req1; ready never high on both.
REQ-032 resp_ready held low 5 cycles in RESP -> resp_valid, resp_result, resp_id constant; req0_ready/req1_ready low; busy high.
REQ-033 EXEC_CYCLES=3, reset asserted in second EXEC cycle -> next cycle IDLE, busy 0, resp_valid never rises; next request completes normally.
REQ-034 req0 valid alone after req0 just served -> req0 granted again immediately (no idle bubble beyond REQ-023).
